// File: rtl/alu_shift_pipe.sv
// Two-stage barrel-shifter + ALU pipeline with valid/ready handshake on both sides.
// The flag register's C feeds both the shifter and the ALU.
module alu_shift_pipe #(
   parameter int WIDTH = 32,
   parameter int SHN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] Shift_Data,
   input  logic [SHN_W-1:0] Shift_Num,
   input  logic [2:0]       SHIFT_OP,
   input  logic [3:0]       ALU_OP,
   input  logic             S,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] F,
   output logic [3:0]       NZCV,
   output logic             out_wr
);
   localparam int RW = $clog2(WIDTH);

   // Returns {carry, result}; the extended shifts leave the last bit shifted out in the spare bit.
   function automatic logic [WIDTH:0] shift_fn(input logic [WIDTH-1:0] d,
                                               input logic [SHN_W-1:0] n,
                                               input logic [2:0]       op,
                                               input logic             cin);
      logic        [WIDTH:0]     lsl_ext;
      logic        [WIDTH:0]     lsr_ext;
      logic signed [WIDTH:0]     asr_ext;
      logic        [2*WIDTH-1:0] ror_ext;
      logic        [RW-1:0]      rot;
      lsl_ext  = {1'b0, d} << n;
      lsr_ext  = {d, 1'b0} >> n;
      asr_ext  = $signed({d, 1'b0}) >>> n;
      rot      = n[RW-1:0];
      ror_ext  = {d, d} >> rot;
      shift_fn = {cin, d};
      if (op == 3'b100) begin
         shift_fn = {d[0], cin, d[WIDTH-1:1]};
      end else if (n != '0) begin
         case (op)
            3'b000:  shift_fn = {lsl_ext[WIDTH], lsl_ext[WIDTH-1:0]};
            3'b001:  shift_fn = {lsr_ext[0], lsr_ext[WIDTH:1]};
            3'b010:  shift_fn = {asr_ext[0], asr_ext[WIDTH:1]};
            3'b011:  shift_fn = {ror_ext[WIDTH-1], ror_ext[WIDTH-1:0]};
            default: shift_fn = {cin, d};
         endcase
      end
   endfunction

   // Returns {result, carry, overflow}. Subtractions are folded into x + ~y + cin.
   function automatic logic [WIDTH+1:0] alu_fn(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [3:0]       op,
                                               input logic             cin,
                                               input logic             sc,
                                               input logic             vin);
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      logic [WIDTH-1:0] res;
      logic [WIDTH:0]   sum;
      logic             ci;
      logic             arith;
      logic             c;
      logic             v;
      x     = a;
      y     = b;
      ci    = 1'b0;
      arith = 1'b1;
      case (op)
         4'h2, 4'hA: begin y = ~b; ci = 1'b1; end
         4'h3:       begin x = ~a; ci = 1'b1; end
         4'h5:       ci = cin;
         4'h6:       begin y = ~b; ci = cin; end
         4'h7:       begin x = ~a; ci = cin; end
         4'h4, 4'hB: ci = 1'b0;
         default:    arith = 1'b0;
      endcase
      sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
      case (op)
         4'h0, 4'h8: res = a & b;
         4'h1, 4'h9: res = a ^ b;
         4'hC:       res = a | b;
         4'hD:       res = b;
         4'hE:       res = a & ~b;
         4'hF:       res = ~b;
         default:    res = sum[WIDTH-1:0];
      endcase
      c = arith ? sum[WIDTH] : sc;
      v = arith ? ((x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1])) : vin;
      alu_fn = {res, c, v};
   endfunction

   logic             vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
   logic [WIDTH-1:0] a_p1_q, a_p1_d, sd_p1_q, sd_p1_d;
   logic [SHN_W-1:0] sn_p1_q, sn_p1_d;
   logic [2:0]       shop_p1_q, shop_p1_d;
   logic [3:0]       aluop_p1_q, aluop_p1_d;
   logic             s_p1_q, s_p1_d;
   logic [WIDTH-1:0] f_p2_q, f_p2_d;
   logic             wr_p2_q, wr_p2_d;
   logic [3:0]       nzcv_q, nzcv_d;
   logic             adv, accept, is_cmp;
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] alu_r;

   always_comb begin
      adv      = !vld_p2_q || out_ready;
      in_ready = !vld_p1_q || adv;
      accept   = in_valid && in_ready;
      is_cmp   = (aluop_p1_q[3:2] == 2'b10);
      shifted  = shift_fn(sd_p1_q, sn_p1_q, shop_p1_q, nzcv_q[1]);
      alu_r    = alu_fn(a_p1_q, shifted[WIDTH-1:0], aluop_p1_q, nzcv_q[1], shifted[WIDTH], nzcv_q[0]);

      a_p1_d     = a_p1_q;
      sd_p1_d    = sd_p1_q;
      sn_p1_d    = sn_p1_q;
      shop_p1_d  = shop_p1_q;
      aluop_p1_d = aluop_p1_q;
      s_p1_d     = s_p1_q;
      vld_p1_d   = vld_p1_q;
      vld_p2_d   = vld_p2_q;
      f_p2_d     = f_p2_q;
      wr_p2_d    = wr_p2_q;
      nzcv_d     = nzcv_q;

      // p0 -> p1: capture accepted operation
      if (accept) begin
         a_p1_d     = A;
         sd_p1_d    = Shift_Data;
         sn_p1_d    = Shift_Num;
         shop_p1_d  = SHIFT_OP;
         aluop_p1_d = ALU_OP;
         s_p1_d     = S;
         vld_p1_d   = 1'b1;
      end else if (adv) begin
         vld_p1_d = 1'b0;
      end

      // p1 -> p2: shift + ALU result into output and flag registers
      if (adv) begin
         vld_p2_d = vld_p1_q;
         if (vld_p1_q) begin
            f_p2_d  = alu_r[WIDTH+1:2];
            wr_p2_d = !is_cmp;
            if (s_p1_q || is_cmp) begin
               nzcv_d = {alu_r[WIDTH+1], (alu_r[WIDTH+1:2] == '0), alu_r[1], alu_r[0]};
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         f_p2_q   <= '0;
         wr_p2_q  <= 1'b0;
         nzcv_q   <= '0;
      end else begin
         vld_p1_q <= vld_p1_d;
         vld_p2_q <= vld_p2_d;
         f_p2_q   <= f_p2_d;
         wr_p2_q  <= wr_p2_d;
         nzcv_q   <= nzcv_d;
      end
   end

   always_ff @(posedge clk) begin
      a_p1_q     <= a_p1_d;
      sd_p1_q    <= sd_p1_d;
      sn_p1_q    <= sn_p1_d;
      shop_p1_q  <= shop_p1_d;
      aluop_p1_q <= aluop_p1_d;
      s_p1_q     <= s_p1_d;
   end

   assign out_valid = vld_p2_q;
   assign F         = f_p2_q;
   assign NZCV      = nzcv_q;
   assign out_wr    = wr_p2_q;

endmodule

// File: tb/tb_alu_shift_pipe.sv
// Directed-vector bench for alu_shift_pipe: behavioural model + queue scoreboard,
// plus literal expectations for the documented example sequences.
module tb_alu_shift_pipe;
   localparam int W = 32;
   localparam longint SMAX = 64'sh7FFFFFFF;
   localparam longint SMIN = -64'sh80000000;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, out_valid, out_ready, S, out_wr;
   logic [W-1:0] A, Shift_Data, F;
   logic [7:0]   Shift_Num;
   logic [2:0]   SHIFT_OP;
   logic [3:0]   ALU_OP, NZCV;

   typedef struct packed {
      logic [W-1:0] f;
      logic [3:0]   nzcv;
      logic         wr;
   } res_t;

   res_t       exp_q[$];
   res_t       last;
   logic [3:0] mdl_flags;
   int         errors = 0;
   int         checks = 0;
   int         n_out  = 0;
   int         n_base;

   alu_shift_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .Shift_Data(Shift_Data), .Shift_Num(Shift_Num), .SHIFT_OP(SHIFT_OP),
      .ALU_OP(ALU_OP), .S(S), .out_valid(out_valid), .out_ready(out_ready),
      .F(F), .NZCV(NZCV), .out_wr(out_wr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
      checks++;
      if (act !== ex) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, ex);
      end
   endtask

   // Reference model written straight from the shift / ALU / flag rules.
   function automatic res_t model_op(input logic [W-1:0] a, input logic [W-1:0] sd,
                                     input int n, input int sop, input int aop,
                                     input bit s, input logic [3:0] fl);
      res_t         r;
      logic [W-1:0] b, res;
      bit           sc, cin, c, v, bw, cmp;
      int           k;
      longint       ua, ub, sa, sb, sum, sr;
      cin = fl[1];
      b   = sd;
      sc  = cin;
      if (sop == 4) begin
         b  = {cin, sd[W-1:1]};
         sc = sd[0];
      end else if (sop <= 3 && n != 0) begin
         case (sop)
            0: if (n < W) begin b = sd << n; sc = sd[W-n]; end
               else begin b = '0; sc = (n == W) ? sd[0] : 1'b0; end
            1: if (n < W) begin b = sd >> n; sc = sd[n-1]; end
               else begin b = '0; sc = (n == W) ? sd[W-1] : 1'b0; end
            2: if (n < W) begin
                  for (int i = 0; i < W; i++) b[i] = (i + n < W) ? sd[i+n] : sd[W-1];
                  sc = sd[n-1];
               end else begin b = {W{sd[W-1]}}; sc = sd[W-1]; end
            default: begin
               k = n % W;
               if (k == 0) begin b = sd; sc = sd[W-1]; end
               else begin
                  for (int i = 0; i < W; i++) b[i] = sd[(i+k)%W];
                  sc = sd[k-1];
               end
            end
         endcase
      end
      ua  = longint'({32'h0, a});
      ub  = longint'({32'h0, b});
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      bw  = !cin;
      c   = sc;
      v   = fl[0];
      sum = 0;
      sr  = 0;
      case (aop)
         4, 11: begin sum = ua + ub;       c = sum[W];         sr = sa + sb; end
         5:     begin sum = ua + ub + cin; c = sum[W];         sr = sa + sb + cin; end
         2, 10: begin sum = ua - ub;       c = (ua >= ub);     sr = sa - sb; end
         3:     begin sum = ub - ua;       c = (ub >= ua);     sr = sb - sa; end
         6:     begin sum = ua - ub - bw;  c = (ua >= ub + bw); sr = sa - sb - bw; end
         7:     begin sum = ub - ua - bw;  c = (ub >= ua + bw); sr = sb - sa - bw; end
         default: ;
      endcase
      case (aop)
         0, 8:    res = a & b;
         1, 9:    res = a ^ b;
         12:      res = a | b;
         13:      res = b;
         14:      res = a & ~b;
         15:      res = ~b;
         default: begin res = sum[W-1:0]; v = (sr > SMAX) || (sr < SMIN); end
      endcase
      cmp    = (aop >= 8 && aop <= 11);
      r.f    = res;
      r.wr   = !cmp;
      r.nzcv = (s || cmp) ? {res[W-1], (res == '0), c, v} : fl;
      return r;
   endfunction

   // Scoreboard bookkeeping on the handshake edges.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         mdl_flags <= '0;
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            last  <= {F, NZCV, out_wr};
            n_out <= n_out + 1;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model_op(A, Shift_Data, int'(Shift_Num), int'(SHIFT_OP),
                                     int'(ALU_OP), S, mdl_flags));
            mdl_flags <= exp_q[exp_q.size()-1].nzcv;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) chk("spurious_out_valid", 1, 0);
         else begin
            chk("F", F, exp_q[0].f);
            chk("NZCV", NZCV, exp_q[0].nzcv);
            chk("out_wr", out_wr, exp_q[0].wr);
         end
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] sd, input int n,
                       input int sop, input int aop, input bit s);
      bit done;
      logic [31:0] nn, so, ao;
      nn = n; so = sop; ao = aop;
      A = a; Shift_Data = sd; Shift_Num = nn[7:0]; SHIFT_OP = so[2:0];
      ALU_OP = ao[3:0]; S = s; in_valid = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      if (!done) chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (!out_valid && exp_q.size() == 0) done = 1'b1;
      end
      if (!done) chk("drain_timeout", 0, 1);
   endtask

   task automatic expect_last(input string nm, input logic [W-1:0] f,
                              input logic [3:0] nzcv, input bit wr);
      chk({nm, "_F"}, last.f, f);
      chk({nm, "_NZCV"}, last.nzcv, nzcv);
      chk({nm, "_wr"}, last.wr, wr);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; A = '0; Shift_Data = '0; Shift_Num = '0;
      SHIFT_OP = '0; ALU_OP = '0; S = 1'b0; out_ready = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_F", F, 0);
      chk("rst_NZCV", NZCV, 0);
      chk("rst_out_wr", out_wr, 0);
      chk("rst_in_ready", in_ready, 1);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Add with wrap to zero; one cycle in S1 before the result appears.
      send(32'hFFFFFFFF, 32'h1, 0, 0, 4, 1);
      chk("lat_s1_only", out_valid, 0);
      @(posedge clk); #1;
      chk("lat_out_valid", out_valid, 1);
      wait_drain();
      expect_last("add_wrap", 32'h0, 4'b0110, 1);

      // Signed overflow, then ADC sees the cleared carry.
      send(32'h7FFFFFFF, 32'h1, 0, 0, 4, 1);
      wait_drain();
      expect_last("add_ovf", 32'h80000000, 4'b1001, 1);
      send(32'h0, 32'h0, 0, 0, 5, 1);
      wait_drain();
      expect_last("adc_c0", 32'h0, 4'b0100, 1);

      // Large shift amounts through MOV.
      send(32'h0, 32'h80000001, 32, 0, 13, 1);
      wait_drain();
      expect_last("lsl32", 32'h0, 4'b0110, 1);
      send(32'h0, 32'h80000001, 33, 1, 13, 1);
      wait_drain();
      expect_last("lsr33", 32'h0, 4'b0100, 1);
      send(32'h0, 32'h80000001, 40, 2, 13, 1);
      wait_drain();
      expect_last("asr40", 32'hFFFFFFFF, 4'b1010, 1);
      send(32'h0, 32'h80000001, 64, 3, 13, 1);
      wait_drain();
      expect_last("ror64", 32'h80000001, 4'b1010, 1);

      // Compare suppresses write-back; RRX uses the carry it left behind.
      send(32'h5, 32'h5, 0, 0, 10, 0);
      wait_drain();
      expect_last("cmp_eq", 32'h0, 4'b0110, 0);
      send(32'h0, 32'h2, 7, 4, 13, 0);
      wait_drain();
      expect_last("rrx", 32'h80000001, 4'b0110, 1);

      // Borrow, then a back-to-back mix checked against the model.
      send(32'h3, 32'h5, 0, 0, 2, 1);
      wait_drain();
      expect_last("sub_borrow", 32'hFFFFFFFE, 4'b1000, 1);
      send(32'h12345678, 32'h0F0F0000, 4, 1, 0, 1);
      send(32'h80000000, 32'h1, 0, 0, 6, 1);
      send(32'h10, 32'h3, 1, 2, 3, 1);
      send(32'h0, 32'h80000000, 1, 3, 7, 1);
      send(32'hFFFF0000, 32'h00FF00FF, 8, 0, 14, 1);
      send(32'h0, 32'hA5, 3, 7, 15, 1);
      send(32'hF0, 32'h0F, 0, 0, 9, 0);
      send(32'h0F, 32'hF0, 0, 0, 8, 0);
      send(32'h40000000, 32'h40000000, 0, 0, 11, 0);
      send(32'h1, 32'h80000000, 31, 2, 1, 1);
      send(32'hAAAA, 32'h5555, 5, 3, 12, 1);
      send(32'h0, 32'h80000000, 1, 0, 13, 1);
      wait_drain();
      chk("mix_last_F", last.f, 32'h0);
      chk("mix_last_ZC", last.nzcv[2:1], 2'b11);

      // Back-pressure: four ops, consumer stalled for three cycles.
      @(posedge clk); #1;
      n_base = n_out;
      out_ready = 1'b0;
      send(32'h0, 32'h11, 0, 0, 13, 0);
      send(32'h1, 32'h2, 0, 0, 4, 0);
      A = 32'hFF; Shift_Data = 32'h0F; ALU_OP = 4'h1; in_valid = 1'b1;
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_F_first", F, 32'h11);
      repeat (2) @(negedge clk);
      chk("stall_F_held", F, 32'h11);
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(32'hFF, 32'h0F, 0, 0, 1, 0);
      send(32'hA, 32'h3, 0, 0, 2, 0);
      wait_drain();
      chk("stall_last_F", last.f, 32'h7);
      chk("stall_count", n_out - n_base, 4);

      // Asynchronous reset while a result is held.
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(32'hFFFFFFFF, 32'h1, 0, 0, 4, 1);
      @(posedge clk); #1;
      chk("pre_rst_out_valid", out_valid, 1);
      chk("pre_rst_NZCV", NZCV, 4'b0110);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_NZCV", NZCV, 0);
      chk("arst_F", F, 0);
      chk("arst_out_wr", out_wr, 0);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      send(32'h0, 32'h0, 0, 0, 5, 1);
      wait_drain();
      expect_last("post_rst_adc", 32'h0, 4'b0100, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_shift_pipe.md
ALU_SHIFT_PIPE -- requirements
Module: alu_shift_pipe

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; legal values 8, 16, 32, 64.
REQ-002 Parameter SHN_W, default 8, shift-amount width; SHN_W >= log2(WIDTH)+1.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operation offered.
REQ-006 in_ready  output  1  operation accepted on edge when in_valid && in_ready.
REQ-007 A  input  WIDTH  first ALU operand.
REQ-008 Shift_Data  input  WIDTH  operand fed through shifter to ALU B.
REQ-009 Shift_Num  input  SHN_W  shift amount, unsigned.
REQ-010 SHIFT_OP  input  3  000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX, others pass-through.
REQ-011 ALU_OP  input  4  0 AND,1 EOR,2 SUB,3 RSB,4 ADD,5 ADC,6 SBC,7 RSC,8 TST,9 TEQ,A CMP,B CMN,C ORR,D MOV,E BIC,F MVN.
REQ-012 S  input  1  update flags.
REQ-013 out_valid  output  1  result register holds a completed operation.
REQ-014 out_ready  input  1  consumer takes result on edge when out_valid && out_ready.
REQ-015 F  output  WIDTH  result.
REQ-016 NZCV  output  4  flag register contents after this operation {N,Z,C,V}.
REQ-017 out_wr  output  1  0 for TST/TEQ/CMP/CMN (F not to be written back), else 1.

Function
REQ-018 Two registered stages: S1 captures accepted inputs; S1 operation computes (shift + ALU) combinationally and is captured into the output register plus flag register on the same edge.
REQ-019 Latency: accepted at edge k -> out_valid high after edge k+1 if output register empty or drained.
REQ-020 in_ready = !s1_valid || !out_valid || out_ready; S1 advances only when !out_valid || out_ready; full throughput one op/cycle with out_ready held high.
REQ-021 Under out_ready=0, F/NZCV/out_wr hold stable while out_valid=1; no op lost or duplicated.
REQ-022 Shifter carry-in and ALU carry-in use the committed flag C; ops execute strictly in order so op n+1 sees flags of op n.
REQ-023 Shift_Num=0 (any op except RRX): output=Shift_Data, shift carry=C.
REQ-024 LSL/LSR by n<WIDTH: standard, carry = last bit shifted out; n=WIDTH: output 0, carry = bit0 (LSL) / MSB (LSR); n>WIDTH: output 0, carry 0.
REQ-025 ASR n>=WIDTH: output all MSB, carry MSB.
REQ-026 ROR: amount mod WIDTH; nonzero multiple of WIDTH: output=Shift_Data, carry=MSB.
REQ-027 RRX: {C, Shift_Data[WIDTH-1:1]}, carry = Shift_Data[0], Shift_Num ignored.
REQ-028 Arithmetic uses WIDTH+1-bit sum; C = carry-out (SUB/CMP: C=1 means no borrow); V = signed overflow.
REQ-029 Logical ops (AND,EOR,TST,TEQ,ORR,MOV,BIC,MVN): C = shift carry, V unchanged.
REQ-030 Flags update when S=1 or op is TST/TEQ/CMP/CMN; N = F[WIDTH-1], Z = (F==0); compare ops compute F internally, F output still driven with computed value.
REQ-031 Flags not updated: NZCV output equals prior flag register.

Reset
REQ-032 rst_n low: s1_valid=0, out_valid=0, F=0, NZCV=0000, out_wr=0, flag register 0, immediately and independently of clk.
REQ-033 Reset mid-operation discards in-flight ops; in_ready=1 on first edge after release.

Verification
REQ-034 WIDTH=32: A=0xFFFFFFFF, Shift_Data=1, LSL 0, ADD, S=1 -> F=0, NZCV=0110, out_wr=1, two edges after accept.
REQ-035 A=0x7FFFFFFF, Shift_Data=1, ADD, S=1 -> F=0x80000000, NZCV=1001; next op ADC with A=0,B=0 -> F=0 (C was 0), NZCV=0100.
REQ-036 Shift_Data=0x80000001: LSL 32 MOV S=1 -> F=0, C=1; LSR 33 -> F=0, C=0; ASR 40 -> F=0xFFFFFFFF, C=1; ROR 64 -> F=0x80000001, C=1.
REQ-037 CMP A=5, B=5 -> out_wr=0, NZCV=0110; then RRX MOV S=0 on 0x2 -> F=0x80000001, flags unchanged.
REQ-038 Back-to-back 4 ops, out_ready=0 for 3 cycles then 1 -> in_ready low after 2 accepts, results emerge in order, values stable while stalled.
REQ-039 rst_n pulsed low asynchronously with out_valid=1 -> out_valid, NZCV cleared before next clk edge; subsequent op uses C=0.
